// File: rtl/sector_ram_pkg.sv
// Shared types and helpers for the sector_ram_dp dual-port sector buffer.
// Optional parity storage is enabled with the SECTOR_RAM_PARITY_EN macro.
package sector_ram_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   // Widest data word the parity helper accepts; callers zero-extend.
   localparam int PAR_MAX_W = 64;

   // Even parity: the stored bit makes the total count of ones even.
   function automatic logic parity_even(input logic [PAR_MAX_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/sector_ram_dp_if.sv
// One RAM access port: enable/direction/address/data plus registered
// read data and read-valid strobe. With SECTOR_RAM_PARITY_EN defined the
// port also carries a parity-error flag.
interface sector_ram_dp_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 13
);
   logic              en_n;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic              valid;
`ifdef SECTOR_RAM_PARITY_EN
   logic              perr;

   modport master (output en_n, rw, addr, din, input dout, valid, perr);
   modport slave  (input en_n, rw, addr, din, output dout, valid, perr);
`else
   modport master (output en_n, rw, addr, din, input dout, valid);
   modport slave  (input en_n, rw, addr, din, output dout, valid);
`endif
endinterface

// File: rtl/sector_ram_port.sv
// Per-port request decode and read-data/valid registers for sector_ram_dp.
// Read data arrives combinationally from the array (pre-edge contents), so
// a same-cycle write on the other port is seen as read-first.
// SECTOR_RAM_PARITY_EN adds the registered parity-error flag.
module sector_ram_port
   import sector_ram_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 13,
   parameter int MEM_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             accept,
   input  logic [MEM_W-1:0] rdata,
   output logic             we,
   sector_ram_dp_if.slave   p
);

   logic              rd_en;
   logic [DATA_W-1:0] dout_d, dout_q;
   logic              valid_d, valid_q;

   // Decode the port request into read or write enables while IDLE.
   always_comb begin
      rd_en = 1'b0;
      we    = 1'b0;
      if (accept && !p.en_n) begin
         rd_en = p.rw;
         we    = ~p.rw;
      end else begin
         rd_en = 1'b0;
         we    = 1'b0;
      end
   end

   // Next read data holds unless a read is accepted; valid pulses per read.
   always_comb begin
      dout_d  = dout_q;
      valid_d = 1'b0;
      if (rd_en) begin
         dout_d  = rdata[DATA_W-1:0];
         valid_d = 1'b1;
      end else begin
         dout_d  = dout_q;
         valid_d = 1'b0;
      end
   end

   // Output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q  <= {DATA_W{1'b0}};
         valid_q <= 1'b0;
      end else begin
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

   assign p.dout  = dout_q;
   assign p.valid = valid_q;

`ifdef SECTOR_RAM_PARITY_EN
   logic perr_d, perr_q;

   // Flag a stored-parity mismatch alongside the read-valid strobe.
   always_comb begin
      perr_d = 1'b0;
      if (rd_en) begin
         perr_d = parity_even(PAR_MAX_W'(rdata[DATA_W-1:0])) ^ rdata[DATA_W];
      end else begin
         perr_d = 1'b0;
      end
   end

   // Parity-error register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end

   assign p.perr = perr_q;
`endif

endmodule

// File: rtl/sector_ram_dp.sv
// Dual-port synchronous sector-buffer RAM with a hardware clear engine.
// Port A is the host side, port B the disk-stream side. On a same-address
// double write port A wins. Optional feature macro: SECTOR_RAM_PARITY_EN
// (one even-parity bit stored per word, perr flag per port).
module sector_ram_dp
   import sector_ram_pkg::*;
#(
   parameter int              DATA_W         = 8,
   parameter int              ADDR_W         = 13,
   parameter logic [DATA_W-1:0] FILL         = {DATA_W{1'b0}},
   parameter bit              CLEAR_ON_RESET = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   output logic           busy,
   sector_ram_dp_if.slave a,
   sector_ram_dp_if.slave b
);

   localparam int DEPTH = 2**ADDR_W;
`ifdef SECTOR_RAM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif
   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

   logic [MEM_W-1:0]  mem [DEPTH];

   state_e            state_d, state_q;
   logic [ADDR_W-1:0] clr_addr_d, clr_addr_q;
   logic              busy_d, busy_q;
   logic              clr_we;
   logic              accept;
   logic              a_we, b_we;
   logic [MEM_W-1:0]  a_rdata, b_rdata;
   logic [MEM_W-1:0]  a_word, b_word, fill_word;

`ifdef SECTOR_RAM_PARITY_EN
   assign fill_word = {parity_even(PAR_MAX_W'(FILL)), FILL};
   assign a_word    = {parity_even(PAR_MAX_W'(a.din)), a.din};
   assign b_word    = {parity_even(PAR_MAX_W'(b.din)), b.din};
`else
   assign fill_word = FILL;
   assign a_word    = a.din;
   assign b_word    = b.din;
`endif

   // Clear FSM state register; reset optionally launches a full clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         clr_addr_q <= {ADDR_W{1'b0}};
         busy_q     <= CLEAR_ON_RESET;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         busy_q     <= busy_d;
      end
   end

   // Clear FSM next state: one FILL word per cycle until the last address.
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (clr) begin
               state_d    = ST_CLEAR;
               clr_addr_d = {ADDR_W{1'b0}};
            end else begin
               state_d    = ST_IDLE;
               clr_addr_d = clr_addr_q;
            end
         end
         ST_CLEAR: begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == LAST_ADDR) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_CLEAR;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            clr_addr_d = {ADDR_W{1'b0}};
         end
      endcase
   end

   // Clear FSM outputs: busy tracks the next state so it is registered.
   always_comb begin
      busy_d = (state_d == ST_CLEAR);
      clr_we = (state_q == ST_CLEAR);
      accept = (state_q == ST_IDLE) && !rst;
   end

   assign busy    = busy_q;
   assign a_rdata = mem[a.addr];
   assign b_rdata = mem[b.addr];

   // Memory array: clear engine owns it while clearing, else port writes
   // with port A taking precedence on a same-address collision.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr_q] <= fill_word;
      end else begin
         if (b_we && !(a_we && (a.addr == b.addr))) begin
            mem[b.addr] <= b_word;
         end
         if (a_we) begin
            mem[a.addr] <= a_word;
         end
      end
   end

   sector_ram_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_W(MEM_W)) u_port_a (
      .clk    (clk),
      .rst    (rst),
      .accept (accept),
      .rdata  (a_rdata),
      .we     (a_we),
      .p      (a)
   );

   sector_ram_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_W(MEM_W)) u_port_b (
      .clk    (clk),
      .rst    (rst),
      .accept (accept),
      .rdata  (b_rdata),
      .we     (b_we),
      .p      (b)
   );

endmodule
